// File: rtl/tff_seq_ctrl.sv
// tff_seq_ctrl: drives a toggle-flip-flop chain with a programmable pulse train
// and counts the transitions seen at the chain's last stage.
//
// A sequence is len data pulses. Each pulse is one cycle of data_out=1, and
// consecutive pulses are separated by gap idle cycles. After the last pulse
// come two drain cycles so the final chain toggle can still be counted. A
// FINISH cycle then raises done for one cycle.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous reset, active low
//   start    begin a sequence (sampled only in IDLE)
//   len      pulse count, latched when start is accepted
//   gap      idle cycles between pulses, latched when start is accepted
//   abort    end the active sequence at the next edge
//   q_in     last stage of the toggle chain (synchronous to clk)
//   data_out toggle enable into the chain, high exactly while in PULSE
//   busy     high whenever the FSM is not in IDLE
//   done     one-cycle pulse on normal completion
//   aborted  one-cycle pulse after an abort
//   sent     pulses issued in the current or last sequence
//   q_edges  q_in transitions seen in the current or last sequence (saturating)
module tff_seq_ctrl #(
    parameter int CW = 8,
    parameter int GW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CW-1:0] len,
    input  logic [GW-1:0] gap,
    input  logic          abort,
    input  logic          q_in,
    output logic          data_out,
    output logic          busy,
    output logic          done,
    output logic          aborted,
    output logic [CW-1:0] sent,
    output logic [CW-1:0] q_edges
);

    typedef enum logic [2:0] {
        IDLE, PULSE, GAP, DRAIN1, DRAIN2, FINISH
    } state_t;

    state_t        state, nxt;
    logic [CW-1:0] len_l;
    logic [CW-1:0] sent_nx;
    logic [GW-1:0] gap_l;
    logic [GW-1:0] gcnt;
    logic          q_d;
    logic          abort_hit;

    assign sent_nx   = sent + 1'b1;
    assign abort_hit = abort && (state != IDLE);

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (start) nxt = (len == '0) ? DRAIN1 : PULSE;
            PULSE: begin
                if (sent_nx == len_l)  nxt = DRAIN1;
                else if (gap_l == '0)  nxt = PULSE;
                else                   nxt = GAP;
            end
            // gcnt counts the remaining gap cycles, including the current one.
            GAP:     nxt = (gcnt <= GW'(1)) ? PULSE : GAP;
            DRAIN1:  nxt = DRAIN2;
            DRAIN2:  nxt = FINISH;
            FINISH:  nxt = IDLE;
            default: nxt = IDLE;
        endcase
        // Abort overrides every other transition, including the exit from FINISH.
        if (abort_hit) nxt = IDLE;
    end

    // Each output is a registered decode of the next state. As a result the
    // outputs line up exactly with the state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            len_l    <= '0;
            gap_l    <= '0;
            gcnt     <= '0;
            q_d      <= 1'b0;
            data_out <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            aborted  <= 1'b0;
            sent     <= '0;
            q_edges  <= '0;
        end else begin
            state    <= nxt;
            q_d      <= q_in;
            data_out <= (nxt == PULSE);
            busy     <= (nxt != IDLE);
            done     <= (nxt == FINISH);
            aborted  <= abort_hit;

            if (state == PULSE && nxt == GAP)
                gcnt <= gap_l;
            else if (nxt == IDLE)
                gcnt <= '0;
            else if (state == GAP)
                gcnt <= gcnt - 1'b1;

            if (state == IDLE && start) begin
                len_l   <= len;
                gap_l   <= gap;
                sent    <= '0;
                q_edges <= '0;
            end else if (state != IDLE && !abort) begin
                // An abort freezes both counters at their current values.
                if (state == PULSE)
                    sent <= sent_nx;
                if (q_in != q_d && q_edges != '1)
                    q_edges <= q_edges + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tff_seq_ctrl.sv
// Testbench for tff_seq_ctrl. It uses a two-stage toggle chain, or optionally a
// free-running toggle source, as the q_in environment. Vectors are checked
// from a table, and the multi-cycle corner cases are written out by hand.
module tb_tff_seq_ctrl;

    logic       clk, rst, start, abort, q_in;
    logic [7:0] len, sent, q_edges;
    logic [3:0] gap;
    logic       data_out, busy, done, aborted;

    // Environment: a 2-stage synchronous toggle chain, or a per-cycle toggler.
    logic q1, q2, tog, tog_mode;
    assign q_in = tog_mode ? tog : q2;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q1  <= 1'b0;
            q2  <= 1'b0;
            tog <= 1'b0;
        end else begin
            q1  <= q1 ^ data_out;
            q2  <= q2 ^ (data_out & q1);
            tog <= ~tog;
        end
    end

    tff_seq_ctrl #(.CW(8), .GW(4)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .gap(gap),
        .abort(abort), .q_in(q_in), .data_out(data_out), .busy(busy),
        .done(done), .aborted(aborted), .sent(sent), .q_edges(q_edges)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Results captured by run_seq.
    int r_np, r_first, r_last, r_done_n, r_done_c, r_ab_n, r_ab_c;
    int r_busy, r_sd, r_qd, r_se;

    // Called at a negedge. Starts a sequence and then watches every cycle
    // until busy drops. abort is raised during cycle ab_at (-1 means never).
    task automatic run_seq(input int l, input int g, input int ab_at);
        bit fin;
        r_np = 0; r_first = -1; r_last = -1; r_done_n = 0; r_done_c = -1;
        r_ab_n = 0; r_ab_c = -1; r_busy = 0; r_sd = -1; r_qd = -1; r_se = -1;
        start = 1'b1; len = 8'(l); gap = 4'(g); abort = 1'b0;
        fin = 1'b0;
        for (int c = 0; c < 300 && !fin; c++) begin
            @(negedge clk);
            start = 1'b0;
            len   = 8'($urandom);
            gap   = 4'($urandom);
            if (data_out) begin
                r_np++;
                if (r_first < 0) r_first = c;
                r_last = c;
            end
            if (busy) r_busy++;
            if (done) begin
                r_done_n++; r_done_c = c; r_sd = int'(sent); r_qd = int'(q_edges);
            end
            if (aborted) begin
                r_ab_n++; r_ab_c = c;
            end
            if (!busy) begin
                fin = 1'b1;
                r_se = int'(sent);
            end
            abort = (c == ab_at);
        end
        abort = 1'b0;
        if (!fin) chk("seq_timeout", 0, 1);
        @(negedge clk);
        chk("post_seq_pulses", int'(done) + int'(aborted), 0);
    endtask

    // Resets with rst going low at a negedge, then releases at the next negedge.
    task automatic do_reset;
        start = 1'b0; abort = 1'b0; tog_mode = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    typedef struct {
        logic       start;
        logic [7:0] len;
        logic [3:0] gap;
        logic       d, b, dn;
        logic [7:0] s, qe;
    } vec_t;
    vec_t tbl[11];

    initial begin
        // len=3, gap=2. Row i gives the inputs before edge i and the outputs after it.
        // Row 4 carries a start that must be ignored while the FSM is busy.
        tbl[0]  = '{1'b1, 8'd3, 4'd2, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0};
        tbl[1]  = '{1'b0, 8'd9, 4'd5, 1'b0, 1'b1, 1'b0, 8'd1, 8'd0};
        tbl[2]  = '{1'b0, 8'd9, 4'd5, 1'b0, 1'b1, 1'b0, 8'd1, 8'd0};
        tbl[3]  = '{1'b0, 8'd9, 4'd5, 1'b1, 1'b1, 1'b0, 8'd1, 8'd0};
        tbl[4]  = '{1'b1, 8'd7, 4'd0, 1'b0, 1'b1, 1'b0, 8'd2, 8'd0};
        tbl[5]  = '{1'b0, 8'd9, 4'd5, 1'b0, 1'b1, 1'b0, 8'd2, 8'd1};
        tbl[6]  = '{1'b0, 8'd9, 4'd5, 1'b1, 1'b1, 1'b0, 8'd2, 8'd1};
        tbl[7]  = '{1'b0, 8'd9, 4'd5, 1'b0, 1'b1, 1'b0, 8'd3, 8'd1};
        tbl[8]  = '{1'b0, 8'd9, 4'd5, 1'b0, 1'b1, 1'b0, 8'd3, 8'd1};
        tbl[9]  = '{1'b0, 8'd9, 4'd5, 1'b0, 1'b1, 1'b1, 8'd3, 8'd1};
        tbl[10] = '{1'b0, 8'd9, 4'd5, 1'b0, 1'b0, 1'b0, 8'd3, 8'd1};

        start = 1'b0; abort = 1'b0; len = '0; gap = '0; tog_mode = 1'b0;
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("reset_data_out", int'(data_out), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_aborted", int'(aborted), 0);
        chk("reset_sent", int'(sent), 0);
        chk("reset_q_edges", int'(q_edges), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Table: len=3, gap=2.
        for (int i = 0; i < 11; i++) begin
            start = tbl[i].start; len = tbl[i].len; gap = tbl[i].gap;
            @(negedge clk);
            chk($sformatf("tbl%0d_data_out", i), int'(data_out), int'(tbl[i].d));
            chk($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].b));
            chk($sformatf("tbl%0d_done", i), int'(done), int'(tbl[i].dn));
            chk($sformatf("tbl%0d_aborted", i), int'(aborted), 0);
            chk($sformatf("tbl%0d_sent", i), int'(sent), int'(tbl[i].s));
            chk($sformatf("tbl%0d_q_edges", i), int'(q_edges), int'(tbl[i].qe));
        end
        start = 1'b0;

        // len=4, gap=0 into the toggle chain.
        do_reset();
        run_seq(4, 0, -1);
        chk("l4_pulses", r_np, 4);
        chk("l4_first_pulse", r_first, 0);
        chk("l4_last_pulse", r_last, 3);
        chk("l4_done_cycle", r_done_c, 6);
        chk("l4_done_count", r_done_n, 1);
        chk("l4_sent", r_sd, 4);
        chk("l4_q_edges", r_qd, 2);

        // len=0: no pulse, done on the 3rd cycle after acceptance.
        run_seq(0, 3, -1);
        chk("l0_pulses", r_np, 0);
        chk("l0_done_cycle", r_done_c, 2);
        chk("l0_busy_cycles", r_busy, 3);
        chk("l0_sent", r_sd, 0);

        // len=8, gap=1, abort during the 3rd GAP (cycle 5).
        do_reset();
        run_seq(8, 1, 5);
        chk("ab_done_count", r_done_n, 0);
        chk("ab_aborted_count", r_ab_n, 1);
        chk("ab_aborted_cycle", r_ab_c, 6);
        chk("ab_sent", r_se, 3);
        chk("ab_pulses", r_np, 3);
        run_seq(2, 0, -1);
        chk("after_ab_pulses", r_np, 2);
        chk("after_ab_done_cycle", r_done_c, 4);
        chk("after_ab_sent", r_sd, 2);

        // Abort alone in IDLE does nothing; start with abort together acts as start.
        abort = 1'b1;
        @(negedge clk);
        chk("idle_abort_aborted", int'(aborted), 0);
        chk("idle_abort_busy", int'(busy), 0);
        start = 1'b1; len = 8'd1; gap = 4'd0;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("start_abort_data_out", int'(data_out), 1);
        chk("start_abort_aborted", int'(aborted), 0);
        begin
            bit idle_seen = 1'b0;
            for (int c = 0; c < 10 && !idle_seen; c++) begin
                @(negedge clk);
                if (!busy) idle_seen = 1'b1;
            end
            chk("start_abort_finished", int'(idle_seen), 1);
            chk("start_abort_sent", int'(sent), 1);
        end

        // Start while busy is ignored; reset mid-PULSE clears outputs at once.
        do_reset();
        start = 1'b1; len = 8'd5; gap = 4'd1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_start_c0_data", int'(data_out), 1);
        @(negedge clk);
        start = 1'b1; len = 8'd1; gap = 4'd0;
        @(negedge clk);
        start = 1'b0;
        chk("busy_start_c2_data", int'(data_out), 1);
        chk("busy_start_c2_sent", int'(sent), 1);
        #2 rst = 1'b0;
        #1;
        chk("midrst_data_out", int'(data_out), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_sent", int'(sent), 0);
        chk("midrst_done_aborted", int'(done) + int'(aborted), 0);
        #1 rst = 1'b1;
        @(negedge clk);
        start = 1'b1; len = 8'd2; gap = 4'd0;
        @(negedge clk);
        start = 1'b0;
        chk("post_rst_start_data", int'(data_out), 1);
        chk("post_rst_start_sent", int'(sent), 0);
        repeat (6) @(negedge clk);

        // len=255, gap=0, q_in toggling every cycle: q_edges saturates.
        do_reset();
        tog_mode = 1'b1;
        run_seq(255, 0, -1);
        chk("sat_pulses", r_np, 255);
        chk("sat_done_cycle", r_done_c, 257);
        chk("sat_busy_cycles", r_busy, 258);
        chk("sat_sent", r_sd, 255);
        chk("sat_q_edges", r_qd, 255);
        tog_mode = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/tff_seq_ctrl.md
TFF_SEQ_CTRL -- requirements
Module: tff_seq_ctrl

Interface
REQ-001 Parameter: CW, default 8, width of the length, sent-count and edge-count fields.
REQ-002 Parameter: GW, default 4, width of the inter-pulse gap field.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request to begin a sequence; sampled only in IDLE.
REQ-006 len  input  CW  number of data pulses to issue; latched on an accepted start.
REQ-007 gap  input  GW  idle cycles between pulses; latched on an accepted start.
REQ-008 abort  input  1  terminates the active sequence.
REQ-009 q_in  input  1  final-stage output of the driven toggle chain; treated as synchronous to clk.
REQ-010 data_out  output  1  toggle-enable (data) driven into the toggle chain.
REQ-011 busy  output  1  high whenever the state is not IDLE.
REQ-012 done  output  1  one-cycle pulse on normal completion.
REQ-013 aborted  output  1  one-cycle pulse on an abort.
REQ-014 sent  output  CW  number of pulses issued in the current or last sequence.
REQ-015 q_edges  output  CW  number of q_in transitions counted in the current or last sequence.

Function
REQ-016 The FSM SHALL have the states IDLE, PULSE, GAP, DRAIN1, DRAIN2 and FINISH.
REQ-017 All outputs SHALL be registered, and data_out SHALL be 1 exactly in the cycles where the state is PULSE.
REQ-018 In IDLE, start=1 SHALL latch len and gap, clear sent and q_edges, and go to PULSE, or go to DRAIN1 if len=0.
REQ-019 start SHALL be ignored in every state other than IDLE.
REQ-020 In PULSE, sent SHALL increment by 1.
REQ-021 PULSE SHALL exit as follows:
- to DRAIN1 if the new sent equals the latched len;
- else back to PULSE if the latched gap=0 (back-to-back pulses);
- else to GAP, loading the gap counter with the latched gap.
REQ-022 GAP SHALL last exactly the latched gap cycles, with data_out=0, then go to PULSE.
REQ-023 DRAIN1 and DRAIN2 SHALL each last one cycle with data_out=0, letting the last chain toggle be counted.
REQ-024 FINISH SHALL assert done for one cycle, then go to IDLE.
REQ-025 q_edges and sent SHALL be stable and final while done=1.
REQ-026 The block SHALL register q_in into q_d every cycle.
REQ-027 q_edges SHALL increment in any non-IDLE cycle where q_in differs from q_d, and SHALL saturate at 2^CW-1.
REQ-028 q_edges SHALL NOT change in IDLE, except the clear on an accepted start.
REQ-029 abort=1 in any non-IDLE state SHALL force IDLE at the next edge, as follows:
- data_out=0 and no done;
- aborted=1 for one cycle;
- sent and q_edges hold their values.
REQ-030 abort has priority over every other transition, including the one out of FINISH.
REQ-031 abort in IDLE SHALL have no effect, and start and abort high together in IDLE SHALL be treated as start only.
REQ-032 Latency: start accepted at edge k SHALL produce data_out=1 in the cycle following edge k.
REQ-033 For len=N and gap=G≥1, a sequence SHALL take N + (N-1)·G + 3 cycles from the first PULSE to the end of FINISH.
REQ-034 The len and gap inputs SHALL be don't-care outside the start-acceptance cycle.

Reset
REQ-035 rst=0 SHALL immediately force the following, independent of clk:
- state=IDLE;
- data_out=0, busy=0, done=0, aborted=0;
- sent=0, q_edges=0, q_d=0;
- gap counter cleared.
REQ-036 Reset asserted mid-sequence SHALL discard the sequence with no done or aborted pulse.
REQ-037 After release, the block SHALL be ready to accept start at the first rising edge.

Verification
REQ-038 len=4, gap=0, q_in driven by a 2-stage toggle chain reset with rst -> data_out high for 4 consecutive cycles, done 3 cycles after the last pulse, sent=4, q_edges=2.
REQ-039 len=3, gap=2 -> data_out pattern 1,0,0,1,0,0,1, then done 3 cycles later, busy high for 10 cycles, sent=3.
REQ-040 len=0 with start -> no data_out pulse, done on the 3rd cycle after acceptance, sent=0.
REQ-041 len=8, gap=1, abort during the 3rd GAP -> aborted pulse next cycle, sent=3, busy=0, no done, and a following start accepted normally.
REQ-042 start pulsed while busy, then reset asserted mid-PULSE -> start ignored, and the reset immediately forces all outputs to 0.
REQ-043 CW=8, len=255, gap=0, q_in toggling every cycle -> q_edges saturates at 255 and sent=255 at done.
